test_frame_checker: RTL and testbench
=====================================

Name: test_frame_checker

Overview:
- Receive-side counterpart of the test frame generator. It sits on one port's RX AXI-Stream after the MAC and classifies every incoming frame.
- It identifies test frames (IPv4, TOS 0xDE, proto 0xFD) and validates the header checksum, length, tuser and payload pattern.
- It accumulates the port_result_t statistics that the controller reads after a test.
- It is purely a sink: there is no tready and it never stalls.

Parameters:
- MAX_FRAME_BYTES, 8191: frames longer than this are test-frame errors.
- MIN_CLASSIFY_BYTES, 40: frames shorter than this are never classified. This is 5 beats, so the full 34-byte header is captured.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- s_axis_tdata  in  64  byte lane k = bits [8k+7:8k]. Lane 0 is the first wire byte.
- s_axis_tkeep  in  8  byte valid, contiguous from lane 0.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  MAC error flag, sampled on the tlast beat.
- s_axis_tvalid  in  1  beat valid.
- count_en  in  1  counting window from the test controller.
- clear  in  1  synchronous zero of all statistics.
- result  out  $bits(port_result_t)  statistics (err_bytes, err_frames, recv_bytes, recv_frames).

Behaviour:
- Reset: result = 0, beat counter = 0, header register = 0, all error flags = 0, pipeline valid = 0. clear has the same effect on result only; a frame in flight continues to be parsed.
- Beat counter (11 bit):
  - counts accepted beats (tvalid=1) within a frame;
  - returns to 0 on the cycle after tlast;
  - saturates at 2047.
  - Back-to-back frames (tlast, then the next beat in the following cycle) must be handled with no bubble.
- Header capture: beats 0..4 are stored lane-for-lane into a 320-bit register. The low 272 bits are read as frame_header_t, with wire byte 0 at the LSB.
- Field comparisons use in-register byte order:
  - ether_type == 16'h0008;
  - version == 4, ihl == 5;
  - tos == `TEST_FRAME_TOS;
  - proto == `TEST_FRAME_PROTO.
- Checksum:
  - computed by the ip_header_checksum instance on the captured ip_header;
  - pass iff the computed value equals the checksum field;
  - the comparison is byte-order independent.
- Byte length: running sum of popcount(tkeep), 14 bit, saturating at 8191+1.
- Per-frame error sticky flag, set by any of:
  - a non-tlast beat with tkeep != 8'hFF;
  - non-contiguous tkeep;
  - tuser=1 on the tlast beat;
  - a payload byte (frame offset n >= 34, n = 8*beat + lane) not equal to n[7:0];
  - length > MAX_FRAME_BYTES;
  - checksum fail.
- Classification on the tlast beat:
  - length < MIN_CLASSIFY_BYTES: ignored.
  - Identity fields mismatch (ethertype, version/ihl, tos, proto): ignored, not a test frame.
  - Otherwise a test frame:
    - error flag = 0: recv_frames += 1, recv_bytes += length;
    - error flag = 1: err_frames += 1, err_bytes += length.
- Pipeline and latency:
  - the tlast beat is registered (classification stage);
  - counters update on the next edge, so result reflects a frame 2 cycles after its tlast beat.
  - One frame can complete per cycle only if it is at least 5 beats long, so no queue is needed.
- count_en is sampled at the tlast beat. If it is 0, the frame is parsed but not counted.
- clear and a counter update on the same cycle: clear wins, and that update is lost.
- Counters are u32 and wrap modulo 2^32 without a flag.
- tvalid=0 mid-frame: the beat counter holds and no state changes.

Decomposition:
- Into tester_common:
  - `MIN_TEST_FRAME_BYTES (40);
  - `ETHERTYPE_IPV4_LE (16'h0008);
  - payload pattern definition (byte = offset mod 256), shared with the generator.
- Reuse ip_header_checksum as the only sub-module. The rest (capture, payload check, counters) is flat in test_frame_checker.

Test Plan:
- Good frame: 64-byte test frame, valid checksum, correct pattern, count_en=1 -> recv_frames=1, recv_bytes=64, err_*=0, two cycles after tlast.
- Corrupted checksum: checksum field off by 1 -> err_frames=1, err_bytes=64, recv_*=0.
- Payload error: byte 50 = 0x00 instead of 0x32 -> err_frames=1.
  - Repeat with tuser=1 on the tlast beat of a good frame -> err_frames=2.
- Non-test traffic ignored:
  - proto=0x11 -> all counters 0;
  - a 39-byte frame -> all counters 0.
- 100 back-to-back 1500-byte frames with no idle cycles -> recv_frames=100, recv_bytes=150000.
  - With count_en dropped before frame 51 -> recv_frames=50.
- Boundaries:
  - clear asserted in the same cycle as a counter update -> result=0;
  - preload via 2^32-1 recv_bytes sequence (force), then add 64 -> recv_bytes wraps to 63;
  - reset mid-frame, then a good frame -> counted exactly once.

Source files
------------

// File: rtl/test_frame_checker_pkg.sv
// Shared tester definitions: test-frame identity, header layout, payload pattern
// and the per-port statistics record read by the test controller.
package test_frame_checker_pkg;

  localparam int unsigned DEF_MAX_FRAME_BYTES  = 8191;
  localparam int unsigned MIN_TEST_FRAME_BYTES = 40;
  localparam int unsigned HEADER_BYTES         = 34;
  localparam logic [15:0] ETHERTYPE_IPV4_LE    = 16'h0008;
  localparam logic [7:0]  TEST_FRAME_TOS       = 8'hDE;
  localparam logic [7:0]  TEST_FRAME_PROTO     = 8'hFD;

  // Wire byte 0 sits at the LSB, so multi-byte fields read byte-swapped.
  typedef struct packed {
    logic [31:0] dst_ip;
    logic [31:0] src_ip;
    logic [15:0] checksum;
    logic [7:0]  proto;
    logic [7:0]  ttl;
    logic [15:0] frag;
    logic [15:0] id;
    logic [15:0] total_len;
    logic [7:0]  tos;
    logic [3:0]  version;
    logic [3:0]  ihl;
  } ip_header_t;

  typedef struct packed {
    ip_header_t  ip;
    logic [15:0] ether_type;
    logic [47:0] src_mac;
    logic [47:0] dst_mac;
  } frame_header_t;

  typedef struct packed {
    logic [31:0] err_bytes;
    logic [31:0] err_frames;
    logic [31:0] recv_bytes;
    logic [31:0] recv_frames;
  } port_result_t;

  // Payload byte at frame offset n is n mod 256; only the low offset byte matters.
  function automatic logic [7:0] payload_byte(input logic [7:0] offset_lo);
    return offset_lo;
  endfunction

endpackage

// File: rtl/test_frame_checker_checksum.sv
// IPv4 header checksum over the captured header, checksum field treated as zero.
// Works on in-register (byte-swapped) words; the one's complement sum is swap-invariant.
module ip_header_checksum
  import test_frame_checker_pkg::*;
(
  input  ip_header_t  i_header,
  output logic [15:0] o_checksum
);

  logic [159:0] w_bits;
  logic [19:0]  w_sum;
  logic [16:0]  w_fold1;
  logic [15:0]  w_fold2;

  assign w_bits = i_header;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 10; i++) begin
      if (i != 5) w_sum = w_sum + {4'b0, w_bits[16*i +: 16]};
    end
  end

  // Nine words fit in 20 bits; two folds absorb every end-around carry.
  assign w_fold1    = {1'b0, w_sum[15:0]} + {13'b0, w_sum[19:16]};
  assign w_fold2    = w_fold1[15:0] + {15'b0, w_fold1[16]};
  assign o_checksum = ~w_fold2;

endmodule

// File: rtl/test_frame_checker.sv
// RX-side test frame checker: captures the header, checks framing and payload
// per beat, classifies on tlast and accumulates per-port statistics.
module test_frame_checker
  import test_frame_checker_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES    = DEF_MAX_FRAME_BYTES,
  parameter int unsigned MIN_CLASSIFY_BYTES = MIN_TEST_FRAME_BYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  s_axis_tdata,
  input  logic [7:0]   s_axis_tkeep,
  input  logic         s_axis_tlast,
  input  logic         s_axis_tuser,
  input  logic         s_axis_tvalid,
  input  logic         count_en,
  input  logic         clear,
  output port_result_t result
);

  localparam logic [13:0] LEN_SAT = 14'(MAX_FRAME_BYTES + 1);
  localparam logic [13:0] LEN_MAX = 14'(MAX_FRAME_BYTES);
  localparam logic [13:0] LEN_MIN = 14'(MIN_CLASSIFY_BYTES);

  logic [10:0]  r_beat;
  logic [319:0] r_hdr;
  logic [13:0]  r_len;
  logic         r_err;
  logic         r_cls_valid;
  logic         r_cls_err;
  logic         r_cls_cnt_en;
  logic [13:0]  r_cls_len;
  logic [31:0]  r_err_bytes;
  logic [31:0]  r_err_frames;
  logic [31:0]  r_recv_bytes;
  logic [31:0]  r_recv_frames;

  logic [3:0]    w_keep_cnt;
  logic          w_pay_err;
  logic [14:0]   w_len_sum;
  logic [13:0]   w_len_next;
  logic          w_keep_contig;
  logic          w_beat_err;
  frame_header_t w_hdr;
  logic [15:0]   w_csum;
  logic          w_ident_ok;
  logic          w_cls_err;
  logic          w_update;
  logic          w_unused;

  always_comb begin
    w_keep_cnt = '0;
    w_pay_err  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_keep_cnt = w_keep_cnt + {3'b0, s_axis_tkeep[k]};
      if (s_axis_tkeep[k] && ({r_beat, 3'(k)} >= 14'(HEADER_BYTES)) &&
          (s_axis_tdata[8*k +: 8] != payload_byte({r_beat[4:0], 3'(k)})))
        w_pay_err = 1'b1;
    end
  end

  assign w_len_sum     = {1'b0, r_len} + {11'b0, w_keep_cnt};
  assign w_len_next    = (w_len_sum > {1'b0, LEN_SAT}) ? LEN_SAT : w_len_sum[13:0];
  // Contiguous-from-lane-0 masks are exactly those of the form 2^m - 1.
  assign w_keep_contig = ((s_axis_tkeep + 8'd1) & s_axis_tkeep) == 8'd0;
  assign w_beat_err    = (!s_axis_tlast && (s_axis_tkeep != 8'hFF)) || !w_keep_contig ||
                         (s_axis_tlast && s_axis_tuser) || w_pay_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat       <= '0;
      r_hdr        <= '0;
      r_len        <= '0;
      r_err        <= 1'b0;
      r_cls_valid  <= 1'b0;
      r_cls_err    <= 1'b0;
      r_cls_cnt_en <= 1'b0;
      r_cls_len    <= '0;
    end else if (s_axis_tvalid) begin
      for (int b = 0; b < 5; b++) begin
        if (r_beat == 11'(b)) r_hdr[64*b +: 64] <= s_axis_tdata;
      end
      r_cls_valid <= s_axis_tlast;
      if (s_axis_tlast) begin
        r_beat       <= '0;
        r_len        <= '0;
        r_err        <= 1'b0;
        r_cls_err    <= r_err | w_beat_err;
        r_cls_len    <= w_len_next;
        r_cls_cnt_en <= count_en;
      end else begin
        r_beat <= (r_beat == 11'h7FF) ? r_beat : r_beat + 11'd1;
        r_len  <= w_len_next;
        r_err  <= r_err | w_beat_err;
      end
    end else begin
      r_cls_valid <= 1'b0;
    end
  end

  // Classification runs the cycle after tlast, when beat 4 has landed in r_hdr
  // and before the next frame's beat 0 can overwrite it.
  assign w_hdr = frame_header_t'(r_hdr[271:0]);

  ip_header_checksum u_csum (
    .i_header   (w_hdr.ip),
    .o_checksum (w_csum)
  );

  assign w_ident_ok = (w_hdr.ether_type == ETHERTYPE_IPV4_LE) &&
                      (w_hdr.ip.version == 4'd4) && (w_hdr.ip.ihl == 4'd5) &&
                      (w_hdr.ip.tos == TEST_FRAME_TOS) && (w_hdr.ip.proto == TEST_FRAME_PROTO);
  assign w_cls_err  = r_cls_err || (r_cls_len > LEN_MAX) || (w_csum != w_hdr.ip.checksum);
  assign w_update   = r_cls_valid && r_cls_cnt_en && (r_cls_len >= LEN_MIN) && w_ident_ok;
  assign w_unused   = ^{r_hdr[319:272], w_hdr.src_mac, w_hdr.dst_mac};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_err_bytes   <= '0;
      r_err_frames  <= '0;
      r_recv_bytes  <= '0;
      r_recv_frames <= '0;
    end else if (w_update) begin
      if (w_cls_err) begin
        r_err_frames <= r_err_frames + 32'd1;
        r_err_bytes  <= r_err_bytes + {18'b0, r_cls_len};
      end else begin
        r_recv_frames <= r_recv_frames + 32'd1;
        r_recv_bytes  <= r_recv_bytes + {18'b0, r_cls_len};
      end
    end
  end

  assign result = '{err_bytes:   r_err_bytes,
                    err_frames:  r_err_frames,
                    recv_bytes:  r_recv_bytes,
                    recv_frames: r_recv_frames};

endmodule

// File: tb/tb_test_frame_checker.sv
// Bench for test_frame_checker: frames are built as byte queues and scored by a
// byte-level reference model of the classification rules.
module tb_test_frame_checker;
  import test_frame_checker_pkg::*;

  typedef byte unsigned bq_t[$];

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic         s_axis_tlast;
  logic         s_axis_tuser;
  logic         s_axis_tvalid;
  logic         count_en;
  logic         clear;
  port_result_t result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_eb = '0, m_ef = '0, m_rb = '0, m_rf = '0;

  test_frame_checker dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .count_en      (count_en),
    .clear         (clear),
    .result        (result)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "time limit");
  end

  function automatic port_result_t mk_res(int unsigned eb, int unsigned ef, int unsigned rb, int unsigned rf);
    port_result_t r;
    r.err_bytes = eb; r.err_frames = ef; r.recv_bytes = rb; r.recv_frames = rf;
    return r;
  endfunction

  function automatic port_result_t model_res();
    return mk_res(m_eb, m_ef, m_rb, m_rf);
  endfunction

  // Standard network-order IPv4 checksum over wire bytes 14..33.
  function automatic logic [15:0] ref_csum(bq_t f);
    int unsigned s = 0;
    for (int i = 0; i < 10; i++)
      if (i != 5) s += 32'({f[14+2*i], f[15+2*i]});
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic bq_t make_frame(int len, logic [7:0] proto);
    bq_t f;
    byte unsigned h[34];
    logic [15:0] c;
    for (int i = 0; i < 34; i++) h[i] = 8'($urandom);
    h[12] = 8'h08; h[13] = 8'h00; h[14] = 8'h45; h[15] = 8'hDE;
    h[16] = 8'((len - 14) >> 8); h[17] = 8'(len - 14);
    h[20] = 8'h00; h[21] = 8'h00; h[22] = 8'd64; h[23] = proto;
    h[24] = 8'h00; h[25] = 8'h00;
    for (int n = 0; n < len; n++) f.push_back((n < 34) ? h[n] : 8'(n));
    if (len >= 34) begin
      c = ref_csum(f);
      f[24] = c[15:8]; f[25] = c[7:0];
    end
    return f;
  endfunction

  task automatic model_frame(input bq_t f, input bit tuser, input bit cen);
    int len = f.size();
    bit err;
    int unsigned add;
    if (!cen || len < 40) return;
    if (!(f[12] == 8'h08 && f[13] == 8'h00 && f[14] == 8'h45 && f[15] == 8'hDE && f[23] == 8'hFD)) return;
    err = tuser || (len > 8191) || (ref_csum(f) != {f[24], f[25]});
    for (int n = 34; n < len; n++) if (f[n] != 8'(n)) err = 1'b1;
    add = (len > 8192) ? 32'd8192 : 32'(len);
    if (err) begin m_ef = m_ef + 32'd1; m_eb = m_eb + add; end
    else     begin m_rf = m_rf + 32'd1; m_rb = m_rb + add; end
  endtask

  task automatic drive_idle();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    s_axis_tkeep = 8'h00; s_axis_tdata = '0;
  endtask

  // Drives beats on falling edges; leaves the last beat on the bus so a following
  // call continues back-to-back. stop_after >= 0 truncates before that beat.
  task automatic send_frame(input bq_t f, input bit tuser, input bit cen, input bit gaps, input int stop_after);
    int nb = (f.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (b == stop_after) return;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(negedge clk);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        if (8*b + k < f.size()) begin
          s_axis_tdata[8*k +: 8] = f[8*b + k]; s_axis_tkeep[k] = 1'b1;
        end else begin
          s_axis_tdata[8*k +: 8] = 8'($urandom); s_axis_tkeep[k] = 1'b0;
        end
      end
      s_axis_tlast  = (b == nb - 1);
      s_axis_tuser  = (b == nb - 1) ? tuser : 1'($urandom);
      s_axis_tvalid = 1'b1;
      count_en      = cen;
    end
  endtask

  task automatic settle();
    repeat (2) begin @(negedge clk); drive_idle(); end
  endtask

  task automatic do_clear();
    @(negedge clk); drive_idle(); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    m_eb = '0; m_ef = '0; m_rb = '0; m_rf = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; count_en = 1'b1; drive_idle();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (result !== mk_res(0, 0, 0, 0)) begin n_bad++; $display("FAIL reset_hold: got %h want 0", result); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (result !== mk_res(0, 0, 0, 0)) begin n_bad++; $display("FAIL reset_release: got %h want 0", result); end
  endtask

  task automatic test_good();
    bq_t f;
    port_result_t prev;
    do_clear();
    prev = model_res();
    f = make_frame(64, TEST_FRAME_PROTO);
    send_frame(f, 1'b0, 1'b1, 1'b0, -1);
    @(negedge clk); drive_idle();
    n_cmp++;
    if (result !== prev) begin n_bad++; $display("FAIL good_latency: got %h want %h one cycle after tlast", result, prev); end
    model_frame(f, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (result !== mk_res(0, 0, 64, 1)) begin n_bad++; $display("FAIL good_frame: got %h want %h", result, mk_res(0, 0, 64, 1)); end
    n_cmp++;
    if (result !== model_res()) begin n_bad++; $display("FAIL good_model: got %h want %h", result, model_res()); end
  endtask

  task automatic test_bad_csum();
    bq_t f;
    logic [15:0] c;
    do_clear();
    f = make_frame(64, TEST_FRAME_PROTO);
    c = {f[24], f[25]} + 16'd1;
    f[24] = c[15:8]; f[25] = c[7:0];
    send_frame(f, 1'b0, 1'b1, 1'b0, -1);
    model_frame(f, 1'b0, 1'b1);
    settle();
    n_cmp++;
    if (result !== mk_res(64, 1, 0, 0)) begin n_bad++; $display("FAIL bad_csum: got %h want %h", result, mk_res(64, 1, 0, 0)); end
  endtask

  task automatic test_payload();
    bq_t f;
    do_clear();
    f = make_frame(64, TEST_FRAME_PROTO);
    f[50] = 8'h00;
    send_frame(f, 1'b0, 1'b1, 1'b0, -1);
    model_frame(f, 1'b0, 1'b1);
    settle();
    n_cmp++;
    if (result !== mk_res(64, 1, 0, 0)) begin n_bad++; $display("FAIL payload_byte50: got %h want %h", result, mk_res(64, 1, 0, 0)); end
    f = make_frame(64, TEST_FRAME_PROTO);
    send_frame(f, 1'b1, 1'b1, 1'b0, -1);
    model_frame(f, 1'b1, 1'b1);
    settle();
    n_cmp++;
    if (result !== mk_res(128, 2, 0, 0)) begin n_bad++; $display("FAIL tuser_err: got %h want %h", result, mk_res(128, 2, 0, 0)); end
  endtask

  task automatic test_non_test();
    bq_t f;
    do_clear();
    f = make_frame(64, 8'h11);
    send_frame(f, 1'b0, 1'b1, 1'b0, -1);
    model_frame(f, 1'b0, 1'b1);
    f = make_frame(39, TEST_FRAME_PROTO);
    send_frame(f, 1'b0, 1'b1, 1'b0, -1);
    model_frame(f, 1'b0, 1'b1);
    settle();
    n_cmp++;
    if (result !== mk_res(0, 0, 0, 0)) begin n_bad++; $display("FAIL non_test_ignored: got %h want 0", result); end
  endtask

  task automatic test_boundaries();
    bq_t f;
    int lens[3] = '{40, 8191, 8192};
    do_clear();
    foreach (lens[i]) begin
      f = make_frame(lens[i], TEST_FRAME_PROTO);
      send_frame(f, 1'b0, 1'b1, 1'b0, -1);
      model_frame(f, 1'b0, 1'b1);
      settle();
      n_cmp++;
      if (result !== model_res()) begin n_bad++; $display("FAIL length_%0d: got %h want %h", lens[i], result, model_res()); end
    end
    n_cmp++;
    if (result !== mk_res(8192, 1, 8231, 2)) begin n_bad++; $display("FAIL length_totals: got %h want %h", result, mk_res(8192, 1, 8231, 2)); end
  endtask

  task automatic test_random();
    bq_t f;
    int len, m, p;
    bit tu, cen;
    do_clear();
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(34, 300);
      f = make_frame(len, TEST_FRAME_PROTO);
      m = $urandom_range(0, 6);
      tu = 1'b0;
      cen = ($urandom_range(0, 9) != 0);
      case (m)
        2: f[25] = 8'(f[25] ^ 8'h01);
        3: if (len > 34) begin p = $urandom_range(34, len - 1); f[p] = 8'(f[p] ^ (8'h01 << $urandom_range(0, 7))); end
        4: tu = 1'b1;
        5: f[15] = 8'h5A;
        6: f[23] = 8'h11;
        default: ;
      endcase
      send_frame(f, tu, cen, 1'($urandom), -1);
      model_frame(f, tu, cen);
      settle();
      n_cmp++;
      if (result !== model_res()) begin n_bad++; $display("FAIL random_frame %0d (len %0d mut %0d): got %h want %h", i, len, m, result, model_res()); end
    end
  endtask

  task automatic test_back_to_back();
    bq_t f;
    for (int run = 0; run < 2; run++) begin
      do_clear();
      for (int i = 0; i < 100; i++) begin
        f = make_frame(1500, TEST_FRAME_PROTO);
        send_frame(f, 1'b0, (run == 0) || (i < 50), 1'b0, -1);
        model_frame(f, 1'b0, (run == 0) || (i < 50));
      end
      settle();
      n_cmp++;
      if (result !== model_res()) begin n_bad++; $display("FAIL back_to_back_run%0d_model: got %h want %h", run, result, model_res()); end
      n_cmp++;
      if (result !== ((run == 0) ? mk_res(0, 0, 150000, 100) : mk_res(0, 0, 75000, 50))) begin
        n_bad++; $display("FAIL back_to_back_run%0d: got %h", run, result);
      end
    end
  endtask

  task automatic test_clear_collision();
    bq_t f;
    do_clear();
    f = make_frame(64, TEST_FRAME_PROTO);
    send_frame(f, 1'b0, 1'b1, 1'b0, -1);
    @(negedge clk); drive_idle(); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    n_cmp++;
    if (result !== mk_res(0, 0, 0, 0)) begin n_bad++; $display("FAIL clear_collision: got %h want 0", result); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (result !== mk_res(0, 0, 0, 0)) begin n_bad++; $display("FAIL clear_update_lost: got %h want 0", result); end
  endtask

  task automatic test_wrap();
    bq_t f;
    do_clear();
    @(negedge clk) force dut.r_recv_bytes = 32'hFFFF_FFFF;
    @(negedge clk) release dut.r_recv_bytes;
    m_rb = 32'hFFFF_FFFF;
    f = make_frame(64, TEST_FRAME_PROTO);
    send_frame(f, 1'b0, 1'b1, 1'b0, -1);
    model_frame(f, 1'b0, 1'b1);
    settle();
    n_cmp++;
    if (result.recv_bytes !== 32'd63) begin n_bad++; $display("FAIL recv_bytes_wrap: got %0d want 63", result.recv_bytes); end
    n_cmp++;
    if (result !== model_res()) begin n_bad++; $display("FAIL wrap_model: got %h want %h", result, model_res()); end
  endtask

  task automatic test_reset_midframe();
    bq_t f;
    f = make_frame(64, TEST_FRAME_PROTO);
    send_frame(f, 1'b0, 1'b1, 1'b0, 3);
    @(negedge clk); drive_idle(); reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    m_eb = '0; m_ef = '0; m_rb = '0; m_rf = '0;
    f = make_frame(64, TEST_FRAME_PROTO);
    send_frame(f, 1'b0, 1'b1, 1'b0, -1);
    model_frame(f, 1'b0, 1'b1);
    settle();
    n_cmp++;
    if (result !== mk_res(0, 0, 64, 1)) begin n_bad++; $display("FAIL reset_midframe: got %h want %h", result, mk_res(0, 0, 64, 1)); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_payload();
    test_non_test();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_clear_collision();
    test_wrap();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
